// File: rtl/fb_pkg.sv
// Shared framebuffer geometry, FSM encoding and address helpers for the pixel responder.
package fb_pkg;

   localparam int unsigned H_RES     = 160;
   localparam int unsigned V_RES     = 120;
   localparam int unsigned COLOUR_W  = 3;
   localparam int unsigned FB_DEPTH  = 19200;
   localparam int unsigned FB_ADDR_W = 15;
   localparam int unsigned X_W       = 8;
   localparam int unsigned Y_W       = 7;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } fb_state_e;

   // y*160 + x without a multiplier
   function automatic logic [FB_ADDR_W-1:0] fb_addr(input logic [X_W-1:0] px,
                                                    input logic [Y_W-1:0] py);
      return (FB_ADDR_W'(py) << 7) + (FB_ADDR_W'(py) << 5) + FB_ADDR_W'(px);
   endfunction

   function automatic logic fb_in_range(input logic [X_W-1:0] px,
                                        input logic [Y_W-1:0] py);
      return (px < X_W'(H_RES)) && (py < Y_W'(V_RES));
   endfunction

endpackage

// File: rtl/fb_ram.sv
// Single-port synchronous pixel store; write wins, read data only changes on a read.
module fb_ram
   import fb_pkg::*;
(
   input  logic                 clk,
   input  logic [FB_ADDR_W-1:0] addr,
   input  logic                 we,
   input  logic                 re,
   input  logic [COLOUR_W-1:0]  wdata,
   output logic [COLOUR_W-1:0]  rdata
);

   logic [COLOUR_W-1:0] r_mem [FB_DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         r_mem[addr] <= wdata;
      end else if (re) begin
         rdata <= r_mem[addr];
      end
   end

endmodule

// File: rtl/fb_pixel_responder.sv
// Framebuffer responder: arbitrates clear sweep, plot writes and pixel reads onto one RAM port.
module fb_pixel_responder
   import fb_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                plot,
   input  logic [X_W-1:0]      x,
   input  logic [Y_W-1:0]      y,
   input  logic [COLOUR_W-1:0] colour,
   output logic                wr_ready,
   input  logic                rd_req,
   input  logic [X_W-1:0]      rd_x,
   input  logic [Y_W-1:0]      rd_y,
   output logic                rd_ready,
   output logic                rd_valid,
   output logic [COLOUR_W-1:0] rd_colour,
   input  logic                clear,
   input  logic [COLOUR_W-1:0] clear_colour,
   output logic                busy,
   output logic                clear_done
);

   localparam logic [FB_ADDR_W-1:0] LAST_ADDR = FB_ADDR_W'(FB_DEPTH - 1);

   fb_state_e             r_state;
   fb_state_e             w_next;
   logic [FB_ADDR_W-1:0]  r_cnt;
   logic [COLOUR_W-1:0]   r_clr_colour;
   logic                  r_rd_zero;
   logic                  w_wr_acc;
   logic                  w_rd_acc;
   logic                  w_rd_in_range;
   logic                  w_sweep_last;
   logic [FB_ADDR_W-1:0]  w_ram_addr;
   logic                  w_ram_we;
   logic                  w_ram_re;
   logic [COLOUR_W-1:0]   w_ram_wdata;
   logic [COLOUR_W-1:0]   w_ram_rdata;

   assign w_wr_acc      = plot && wr_ready;
   assign w_rd_acc      = rd_req && rd_ready;
   assign w_rd_in_range = fb_in_range(rd_x, rd_y);
   assign w_sweep_last  = (r_state == CLEAR) && (r_cnt == LAST_ADDR);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (clear) w_next = CLEAR;
         CLEAR:   if (r_cnt == LAST_ADDR) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Handshakes are withheld during reset and in the cycle a clear is taken
   always_comb begin
      wr_ready = 1'b0;
      rd_ready = 1'b0;
      busy     = 1'b0;
      case (r_state)
         IDLE: begin
            wr_ready = !reset && !clear;
            rd_ready = !reset && !clear && !plot;
         end
         CLEAR: busy = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt        <= '0;
         r_clr_colour <= '0;
         rd_valid     <= 1'b0;
         r_rd_zero    <= 1'b1;
         clear_done   <= 1'b0;
      end else begin
         rd_valid   <= w_rd_acc;
         clear_done <= w_sweep_last;
         if (w_rd_acc) begin
            r_rd_zero <= !w_rd_in_range;
         end
         if ((r_state == IDLE) && clear) begin
            r_cnt        <= '0;
            r_clr_colour <= clear_colour;
         end else if (r_state == CLEAR) begin
            r_cnt <= w_sweep_last ? '0 : r_cnt + FB_ADDR_W'(1);
         end
      end
   end

   // RAM port mux: sweep > plot > read; out-of-range plots and reads never touch the RAM
   always_comb begin
      w_ram_addr  = fb_addr(rd_x, rd_y);
      w_ram_we    = 1'b0;
      w_ram_re    = w_rd_acc && w_rd_in_range;
      w_ram_wdata = colour;
      if (r_state == CLEAR) begin
         w_ram_addr  = r_cnt;
         w_ram_we    = 1'b1;
         w_ram_re    = 1'b0;
         w_ram_wdata = r_clr_colour;
      end else if (w_wr_acc) begin
         w_ram_addr = fb_addr(x, y);
         w_ram_we   = fb_in_range(x, y);
         w_ram_re   = 1'b0;
      end
   end

   fb_ram u_ram (
      .clk   (clk),
      .addr  (w_ram_addr),
      .we    (w_ram_we),
      .re    (w_ram_re),
      .wdata (w_ram_wdata),
      .rdata (w_ram_rdata)
   );

   assign rd_colour = r_rd_zero ? COLOUR_W'(0) : w_ram_rdata;

endmodule

// File: tb/tb_fb_pixel_responder.sv
// Directed bench for fb_pixel_responder with a read-response scoreboard.
module tb_fb_pixel_responder;

   logic       clk = 1'b0;
   logic       reset;
   logic       plot;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] colour;
   logic       wr_ready;
   logic       rd_req;
   logic [7:0] rd_x;
   logic [6:0] rd_y;
   logic       rd_ready;
   logic       rd_valid;
   logic [2:0] rd_colour;
   logic       clear;
   logic [2:0] clear_colour;
   logic       busy;
   logic       clear_done;

   fb_pixel_responder dut (
      .clk          (clk),
      .reset        (reset),
      .plot         (plot),
      .x            (x),
      .y            (y),
      .colour       (colour),
      .wr_ready     (wr_ready),
      .rd_req       (rd_req),
      .rd_x         (rd_x),
      .rd_y         (rd_y),
      .rd_ready     (rd_ready),
      .rd_valid     (rd_valid),
      .rd_colour    (rd_colour),
      .clear        (clear),
      .clear_colour (clear_colour),
      .busy         (busy),
      .clear_done   (clear_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [2:0] col;
      int         due;
   } exp_t;

   exp_t sb[$];
   int   n_vec  = 0;
   int   n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: every rd_valid must match the oldest expected response and its cycle
   always @(negedge clk) begin
      exp_t e;
      if (!reset && rd_valid) begin
         if (sb.size() == 0) begin
            chk("unexpected_rd_valid", 32'(rd_colour), 32'hFFFF_FFFF);
         end else begin
            e = sb.pop_front();
            chk("rd_colour", 32'(rd_colour), 32'(e.col));
            chk("rd_latency", 32'(cyc), 32'(e.due));
         end
      end
   end

   task automatic wr(input int xx, input int yy, input logic [2:0] c);
      bit ok = 0;
      plot = 1'b1; x = 8'(xx); y = 7'(yy); colour = c;
      for (int n = 0; n < 100 && !ok; n++) begin
         @(negedge clk);
         ok = wr_ready;
      end
      if (!ok) chk("wr_timeout", 0, 1);
      @(posedge clk); #1;
      plot = 1'b0;
   endtask

   task automatic rd(input int xx, input int yy, input logic [2:0] c);
      bit ok = 0;
      rd_req = 1'b1; rd_x = 8'(xx); rd_y = 7'(yy);
      for (int n = 0; n < 100 && !ok; n++) begin
         @(negedge clk);
         ok = rd_ready;
      end
      if (ok) sb.push_back('{col: c, due: cyc + 1});
      else    chk("rd_timeout", 0, 1);
      @(posedge clk); #1;
      rd_req = 1'b0;
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int  nb;
      int  bad;
      bit  done;
      reset = 1'b1; plot = 1'b0; rd_req = 1'b0; clear = 1'b0;
      x = '0; y = '0; colour = '0; rd_x = '0; rd_y = '0; clear_colour = '0;

      repeat (3) @(negedge clk);
      chk("rst_wr_ready",   32'(wr_ready),   0);
      chk("rst_rd_ready",   32'(rd_ready),   0);
      chk("rst_rd_valid",   32'(rd_valid),   0);
      chk("rst_rd_colour",  32'(rd_colour),  0);
      chk("rst_busy",       32'(busy),       0);
      chk("rst_clear_done", 32'(clear_done), 0);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("idle_wr_ready", 32'(wr_ready), 1);

      // write then immediate readback, then hold of rd_colour
      wr(5, 3, 3'b101);
      rd(5, 3, 3'b101);
      repeat (3) @(negedge clk);
      chk("rd_colour_hold", 32'(rd_colour), 5);
      @(posedge clk); #1;

      // corner addresses
      wr(0, 0, 3'b001);
      wr(159, 119, 3'b110);
      rd(0, 0, 3'b001);
      rd(159, 119, 3'b110);
      rd(5, 3, 3'b101);

      // out of range write is dropped, neighbour untouched
      wr(0, 10, 3'b011);
      wr(160, 10, 3'b111);
      rd(160, 10, 3'b000);
      rd(0, 10, 3'b011);

      // plot held four cycles stalls a pending read
      plot = 1'b1; rd_req = 1'b1; rd_x = 8'd12; rd_y = 7'd20;
      for (int i = 0; i < 4; i++) begin
         x = 8'(10 + i); y = 7'd20; colour = 3'(i + 1);
         @(negedge clk);
         chk("stall_rd_ready", 32'(rd_ready), 0);
         chk("stall_wr_ready", 32'(wr_ready), 1);
         @(posedge clk); #1;
      end
      plot = 1'b0;
      @(negedge clk);
      chk("unstall_rd_ready", 32'(rd_ready), 1);
      sb.push_back('{col: 3'd3, due: cyc + 1});
      @(posedge clk); #1;
      rd_req = 1'b0;
      rd(13, 20, 3'd4);

      // reset part-way through a sweep; address 5000 = (40,31) keeps its value
      wr(40, 31, 3'b101);
      clear_colour = 3'b111; clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      repeat (1000) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("midclr_busy",       32'(busy),       0);
      chk("midclr_wr_ready",   32'(wr_ready),   0);
      chk("midclr_rd_ready",   32'(rd_ready),   0);
      chk("midclr_rd_valid",   32'(rd_valid),   0);
      chk("midclr_rd_colour",  32'(rd_colour),  0);
      chk("midclr_clear_done", 32'(clear_done), 0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("postrst_busy", 32'(busy), 0);
      rd(40, 31, 3'b101);
      rd(0, 0, 3'b111);

      // full sweep; plot/rd_req raised with clear must not be taken
      clear_colour = 3'b010; clear = 1'b1; plot = 1'b1; rd_req = 1'b1;
      x = 8'd1; y = 7'd1; colour = 3'b111;
      @(negedge clk);
      chk("clracc_wr_ready", 32'(wr_ready), 0);
      chk("clracc_rd_ready", 32'(rd_ready), 0);
      @(posedge clk); #1;
      clear = 1'b0; plot = 1'b0; rd_req = 1'b0;
      nb = 0; bad = 0; done = 0;
      for (int n = 0; n < 25000 && !done; n++) begin
         @(negedge clk);
         if (busy) begin
            nb++;
            if (wr_ready || rd_ready || clear_done) bad++;
            clear = (nb == 5000);
         end else begin
            done = 1;
         end
      end
      clear = 1'b0;
      chk("sweep_ended", 32'(done), 1);
      chk("busy_cycles", 32'(nb), 19200);
      chk("sweep_ready_low", 32'(bad), 0);
      chk("clear_done_pulse", 32'(clear_done), 1);
      @(negedge clk);
      chk("clear_done_single", 32'(clear_done), 0);
      chk("post_sweep_busy", 32'(busy), 0);
      @(posedge clk); #1;
      for (int i = 0; i < 20; i++) begin
         rd(int'($urandom_range(0, 159)), int'($urandom_range(0, 119)), 3'b010);
      end
      rd(159, 119, 3'b010);

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", 32'(sb.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
